bus_mailbox: RTL and testbench

// - Memory-mapped I/O responder on the processor bus: address/wr_data/wr_enable
//   in, rd_data out. It sits beside memory_block on that bus.
// - It owns a 4-byte register window at BASE_ADDR. Two byte FIFOs bridge the

---
 rtl/mailbox_pkg.sv | 41 ++++
 rtl/byte_fifo.sv | 76 +++++++
 rtl/bus_mailbox.sv | 135 +++++++++++++
 tb/tb_bus_mailbox.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mailbox_pkg.sv
// mailbox_pkg: shared constants for the bus mailbox.
// - Register offsets within the 4-byte window.
// - STATUS and CTRL bit positions.
// - pack_status(): assembles the STATUS byte from individual flags.
package mailbox_pkg;

    localparam logic [1:0] OFF_TXDATA = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;
    localparam logic [1:0] OFF_RXDATA = 2'd2;
    localparam logic [1:0] OFF_CTRL   = 2'd3;

    localparam int unsigned ST_TX_FULL  = 7;
    localparam int unsigned ST_TX_EMPTY = 6;
    localparam int unsigned ST_RX_FULL  = 5;
    localparam int unsigned ST_RX_EMPTY = 4;
    localparam int unsigned ST_OVF      = 3;
    localparam int unsigned ST_UNF      = 2;

    localparam int unsigned CTRL_CLR   = 0;
    localparam int unsigned CTRL_FLUSH = 1;

    function automatic logic [7:0] pack_status(
        input logic tx_full,
        input logic tx_empty,
        input logic rx_full,
        input logic rx_empty,
        input logic ovf,
        input logic unf
    );
        logic [7:0] s;
        s              = 8'h00;
        s[ST_TX_FULL]  = tx_full;
        s[ST_TX_EMPTY] = tx_empty;
        s[ST_RX_FULL]  = rx_full;
        s[ST_RX_EMPTY] = rx_empty;
        s[ST_OVF]      = ovf;
        s[ST_UNF]      = unf;
        return s;
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// byte_fifo: register-array byte FIFO with first-word-fall-through head.
// Ports:
//   clk_i, reset_i      clock, asynchronous active-high reset
//   push_i, din_i       push request and data
//   pop_i               pop request (ignored when empty)
//   flush_i             empties the FIFO; wins over push/pop
//   dout_o              head byte, 8'h00 while empty
//   full_o, empty_o     occupancy flags
//   count_o             number of stored bytes, 0..DEPTH
module byte_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned PTR_W = 3
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             push_i,
    input  logic [7:0]       din_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic [7:0]       dout_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [PTR_W:0]   count_o
);

    localparam logic [PTR_W:0] FullCount = (PTR_W + 1)'(DEPTH);

    logic [7:0]       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             push_ok, pop_ok;

    assign full_o  = (count_q == FullCount);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign dout_o  = empty_o ? 8'h00 : mem_q[rd_ptr_q];

    // A push into a full FIFO is accepted when a pop frees the head slot in the same cycle.
    assign pop_ok  = pop_i & ~empty_o;
    assign push_ok = push_i & (~full_o | pop_i);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Power-of-two depth: pointers wrap naturally.
            if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + {{PTR_W{1'b0}}, push_ok} - {{PTR_W{1'b0}}, pop_ok};
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: dout_o is masked while empty.
    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/bus_mailbox.sv
// bus_mailbox: memory-mapped mailbox bridging the processor bus to a byte-stream agent.
// Ports:
//   clk_i, reset_i                  clock, asynchronous active-high reset
//   address_i, wr_enable_i,
//   wr_data_i                       processor bus access
//   rd_data_o, hit_o                registered read data and window-hit flag
//   tx_data_o, tx_valid_o,
//   tx_ready_i                      TX FIFO drain side (agent)
//   rx_data_i, rx_valid_i,
//   rx_ready_o                      RX FIFO fill side (agent)
// Window at BASE_ADDR: +0 TXDATA, +1 STATUS, +2 RXDATA, +3 CTRL.
module bus_mailbox
    import mailbox_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = 16'hD000,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned PTR_W     = 3
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [15:0] address_i,
    input  logic        wr_enable_i,
    input  logic [7:0]  wr_data_i,
    output logic [7:0]  rd_data_o,
    output logic        hit_o,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic        rx_ready_o
);

    localparam logic [PTR_W:0] FullCount = (PTR_W + 1)'(DEPTH);

    logic           sel;
    logic [1:0]     off;
    logic           tx_push, tx_full, tx_empty;
    logic           rx_pop, rx_push, rx_full, rx_empty;
    logic [PTR_W:0] tx_count, rx_count;
    logic [7:0]     rx_dout;
    logic           ctrl_wr, clr, flush;
    logic           ovf_set, unf_set;
    logic           ovf_q, ovf_d, unf_q, unf_d;
    logic [7:0]     rd_data_q, rd_data_d;
    logic           hit_q;
    logic [7:0]     status;

    assign sel = (address_i[15:2] == BASE_ADDR[15:2]);
    assign off = address_i[1:0];

    assign tx_push = sel & wr_enable_i & (off == OFF_TXDATA);
    assign rx_pop  = sel & ~wr_enable_i & (off == OFF_RXDATA);
    assign rx_push = rx_valid_i & ~rx_full;
    assign ctrl_wr = sel & wr_enable_i & (off == OFF_CTRL);
    assign clr     = ctrl_wr & wr_data_i[CTRL_CLR];
    assign flush   = ctrl_wr & wr_data_i[CTRL_FLUSH];

    // A full TX FIFO still accepts the byte when the agent drains the head this cycle.
    assign ovf_set = tx_push & tx_full & ~tx_ready_i;
    assign unf_set = rx_pop & rx_empty;

    // Set has priority over clear.
    assign ovf_d = ovf_set | (ovf_q & ~clr);
    assign unf_d = unf_set | (unf_q & ~clr);

    // Flags sampled before this cycle's updates.
    assign status = pack_status(tx_count == FullCount, tx_count == '0,
                                rx_count == FullCount, rx_count == '0, ovf_q, unf_q);

    always_comb begin
        rd_data_d = 8'h00;
        if (sel && !wr_enable_i) begin
            unique case (off)
                OFF_TXDATA: rd_data_d = 8'h00;
                OFF_STATUS: rd_data_d = status;
                OFF_RXDATA: rd_data_d = rx_dout;
                OFF_CTRL:   rd_data_d = 8'h00;
                default:    rd_data_d = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rd_data_q <= 8'h00;
            hit_q     <= 1'b0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
        end else begin
            rd_data_q <= rd_data_d;
            hit_q     <= sel;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
        end
    end

    assign rd_data_o  = rd_data_q;
    assign hit_o      = hit_q;
    assign tx_valid_o = ~tx_empty;
    assign rx_ready_o = ~rx_full;

    byte_fifo #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_tx_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .push_i  (tx_push),
        .din_i   (wr_data_i),
        .pop_i   (tx_ready_i),
        .flush_i (flush),
        .dout_o  (tx_data_o),
        .full_o  (tx_full),
        .empty_o (tx_empty),
        .count_o (tx_count)
    );

    byte_fifo #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_rx_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .push_i  (rx_push),
        .din_i   (rx_data_i),
        .pop_i   (rx_pop),
        .flush_i (flush),
        .dout_o  (rx_dout),
        .full_o  (rx_full),
        .empty_o (rx_empty),
        .count_o (rx_count)
    );

endmodule

// File: tb/tb_bus_mailbox.sv
module tb_bus_mailbox;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] address;
    logic        wr_enable;
    logic [7:0]  wr_data;
    logic [7:0]  rd_data;
    logic        hit;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;

    always #5 clk = ~clk;

    bus_mailbox #(
        .BASE_ADDR (16'hD000),
        .DEPTH     (8),
        .PTR_W     (3)
    ) dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .address_i   (address),
        .wr_enable_i (wr_enable),
        .wr_data_i   (wr_data),
        .rd_data_o   (rd_data),
        .hit_o       (hit),
        .tx_data_o   (tx_data),
        .tx_valid_o  (tx_valid),
        .tx_ready_i  (tx_ready),
        .rx_data_i   (rx_data),
        .rx_valid_i  (rx_valid),
        .rx_ready_o  (rx_ready)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: two byte queues plus sticky flags.
    logic [7:0] txq[$];
    logic [7:0] rxq[$];
    bit         m_ovf, m_unf;
    logic [7:0] exp_rd;
    bit         exp_hit;

    function automatic logic [7:0] m_status();
        return {txq.size() == 8, txq.size() == 0, rxq.size() == 8, rxq.size() == 0,
                m_ovf, m_unf, 2'b00};
    endfunction

    function automatic logic [7:0] m_tx_head();
        return (txq.size() != 0) ? txq[0] : 8'h00;
    endfunction

    // One bus cycle: drive inputs, advance model by the spec rules, step past the edge.
    task automatic cycle(input logic [15:0] a, input bit we, input logic [7:0] wd,
                         input bit txr, input bit rxv, input logic [7:0] rxd);
        bit         sel, tx_full0, tx_pop, rx_empty0, rx_full0, ovf_set, unf_set, clr, flush;
        logic [1:0] off;
        address   = a;
        wr_enable = we;
        wr_data   = wd;
        tx_ready  = txr;
        rx_valid  = rxv;
        rx_data   = rxd;
        sel       = (a[15:2] == 14'h3400);
        off       = a[1:0];
        ovf_set   = 1'b0;
        unf_set   = 1'b0;
        exp_hit   = sel;
        exp_rd    = 8'h00;
        tx_full0  = (txq.size() == 8);
        tx_pop    = (txq.size() != 0) && txr;
        rx_empty0 = (rxq.size() == 0);
        rx_full0  = (rxq.size() == 8);
        if (sel && !we && off == 2'd1) exp_rd = m_status();
        if (sel && !we && off == 2'd2) begin
            if (rx_empty0) unf_set = 1'b1;
            else exp_rd = rxq.pop_front();
        end
        if (tx_pop) void'(txq.pop_front());
        if (sel && we && off == 2'd0) begin
            if (tx_full0 && !tx_pop) ovf_set = 1'b1;
            else txq.push_back(wd);
        end
        if (rxv && !rx_full0) rxq.push_back(rxd);
        clr   = sel && we && off == 2'd3 && wd[0];
        flush = sel && we && off == 2'd3 && wd[1];
        m_ovf = ovf_set | (m_ovf & !clr);
        m_unf = unf_set | (m_unf & !clr);
        if (flush) begin
            txq.delete();
            rxq.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit txr);
        cycle(16'h0000, 1'b0, 8'h00, txr, 1'b0, 8'h00);
    endtask

    task automatic do_reset();
        address   = 16'h0000;
        wr_enable = 1'b0;
        wr_data   = 8'h00;
        tx_ready  = 1'b0;
        rx_valid  = 1'b0;
        rx_data   = 8'h00;
        reset     = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        txq.delete();
        rxq.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 4; i++) cycle(16'hD000, 1'b1, 8'(i + 1), 1'b0, 1'b0, 8'h00);
        // Asynchronous assertion in the middle of the cycle.
        #2;
        reset = 1'b1;
        #1;
        n_tests++;
        if (tx_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_tx_valid: got %b want 0", tx_valid);
        end
        n_tests++;
        if (rx_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_rx_ready: got %b want 1", rx_ready);
        end
        n_tests++;
        if (hit !== 1'b0 || rd_data !== 8'h00 || tx_data !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_outputs: hit=%b rd=%h txd=%h want 0/00/00", hit, rd_data, tx_data);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        txq.delete();
        rxq.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        cycle(16'hD001, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        n_tests++;
        if (rd_data !== 8'h50 || hit !== 1'b1) begin
            n_fail++; $display("FAIL reset_status: got %h hit=%b want 50 hit=1", rd_data, hit);
        end
    endtask

    task automatic test_tx_path();
        do_reset();
        cycle(16'hD000, 1'b1, 8'h41, 1'b0, 1'b0, 8'h00);
        cycle(16'hD000, 1'b1, 8'h42, 1'b0, 1'b0, 8'h00);
        n_tests++;
        if (tx_valid !== 1'b1 || tx_data !== 8'h41) begin
            n_fail++; $display("FAIL tx_head: got v=%b d=%h want 1/41", tx_valid, tx_data);
        end
        idle(1'b1);
        n_tests++;
        if (tx_valid !== 1'b1 || tx_data !== 8'h42) begin
            n_fail++; $display("FAIL tx_second: got v=%b d=%h want 1/42", tx_valid, tx_data);
        end
        idle(1'b1);
        n_tests++;
        if (tx_valid !== 1'b0) begin
            n_fail++; $display("FAIL tx_drained: got v=%b want 0", tx_valid);
        end
    endtask

    task automatic test_tx_overflow();
        do_reset();
        for (int i = 0; i < 9; i++) cycle(16'hD000, 1'b1, 8'(i), 1'b0, 1'b0, 8'h00);
        cycle(16'hD001, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        n_tests++;
        if (rd_data !== 8'h98) begin
            n_fail++; $display("FAIL ovf_status: got %h want 98", rd_data);
        end
        for (int i = 0; i < 8; i++) begin
            n_tests++;
            if (tx_valid !== 1'b1 || tx_data !== 8'(i)) begin
                n_fail++;
                $display("FAIL ovf_drain[%0d]: got v=%b d=%h want 1/%h", i, tx_valid, tx_data, 8'(i));
            end
            idle(1'b1);
        end
        n_tests++;
        if (tx_valid !== 1'b0) begin
            n_fail++; $display("FAIL ovf_dropped: got v=%b d=%h want v=0", tx_valid, tx_data);
        end
    endtask

    task automatic test_rx_path();
        logic [7:0] want [3];
        want[0] = 8'h5A;
        want[1] = 8'hA5;
        want[2] = 8'h00;
        do_reset();
        cycle(16'h0000, 1'b0, 8'h00, 1'b0, 1'b1, 8'h5A);
        cycle(16'h0000, 1'b0, 8'h00, 1'b0, 1'b1, 8'hA5);
        for (int i = 0; i < 3; i++) begin
            cycle(16'hD002, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
            n_tests++;
            if (rd_data !== want[i] || hit !== 1'b1) begin
                n_fail++;
                $display("FAIL rx_read[%0d]: got %h hit=%b want %h hit=1", i, rd_data, hit, want[i]);
            end
        end
        cycle(16'hD001, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        n_tests++;
        if (rd_data !== 8'h54) begin
            n_fail++; $display("FAIL rx_unf_status: got %h want 54", rd_data);
        end
    endtask

    task automatic test_full_simul();
        logic [7:0] want [8];
        do_reset();
        for (int i = 0; i < 8; i++) cycle(16'hD000, 1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 8'h00);
        cycle(16'hD000, 1'b1, 8'h77, 1'b1, 1'b0, 8'h00);
        cycle(16'hD001, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        n_tests++;
        if (rd_data !== 8'h90) begin
            n_fail++; $display("FAIL simul_status: got %h want 90", rd_data);
        end
        for (int i = 0; i < 7; i++) want[i] = 8'(8'h11 + i);
        want[7] = 8'h77;
        for (int i = 0; i < 8; i++) begin
            n_tests++;
            if (tx_valid !== 1'b1 || tx_data !== want[i]) begin
                n_fail++;
                $display("FAIL simul_drain[%0d]: got v=%b d=%h want 1/%h", i, tx_valid, tx_data, want[i]);
            end
            idle(1'b1);
        end
        n_tests++;
        if (tx_valid !== 1'b0) begin
            n_fail++; $display("FAIL simul_empty: got v=%b want 0", tx_valid);
        end
    endtask

    task automatic test_ctrl();
        do_reset();
        for (int i = 0; i < 9; i++) cycle(16'hD000, 1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, 8'h00);
        cycle(16'h0000, 1'b0, 8'h00, 1'b0, 1'b1, 8'h33);
        cycle(16'hD001, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        n_tests++;
        if (rd_data !== 8'h88) begin
            n_fail++; $display("FAIL ctrl_pre_status: got %h want 88", rd_data);
        end
        cycle(16'hD003, 1'b1, 8'h03, 1'b0, 1'b0, 8'h00);
        cycle(16'hD001, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        n_tests++;
        if (rd_data !== 8'h50) begin
            n_fail++; $display("FAIL ctrl_status: got %h want 50", rd_data);
        end
        cycle(16'hD004, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        n_tests++;
        if (hit !== 1'b0 || rd_data !== 8'h00) begin
            n_fail++; $display("FAIL out_of_window: got hit=%b rd=%h want 0/00", hit, rd_data);
        end
        n_tests++;
        if (tx_valid !== 1'b0 || rx_ready !== 1'b1) begin
            n_fail++; $display("FAIL ctrl_flush: got txv=%b rxr=%b want 0/1", tx_valid, rx_ready);
        end
    endtask

    task automatic test_random();
        logic [15:0] a;
        logic [7:0]  wd;
        int          r;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            if (n == 300) do_reset();
            r = int'($urandom_range(0, 9));
            if (r < 7) a = 16'hD000 + 16'($urandom_range(0, 3));
            else if (r == 7) a = 16'hD004;
            else if (r == 8) a = 16'hCFFF;
            else a = 16'($urandom);
            wd = 8'($urandom);
            // Keep CTRL writes rare so the FIFOs get a chance to fill.
            if (a == 16'hD003 && $urandom_range(0, 3) != 0) a = 16'hD001;
            cycle(a, 1'($urandom), wd, ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 1) == 0), 8'($urandom));
            n_tests++;
            if (rd_data !== exp_rd || hit !== exp_hit) begin
                n_fail++;
                $display("FAIL rand_read[%0d]: got %h hit=%b want %h hit=%b",
                         n, rd_data, hit, exp_rd, exp_hit);
            end
            n_tests++;
            if (tx_valid !== (txq.size() != 0) || tx_data !== m_tx_head()) begin
                n_fail++;
                $display("FAIL rand_tx[%0d]: got v=%b d=%h want %b/%h",
                         n, tx_valid, tx_data, txq.size() != 0, m_tx_head());
            end
            n_tests++;
            if (rx_ready !== (rxq.size() < 8)) begin
                n_fail++;
                $display("FAIL rand_rx_ready[%0d]: got %b want %b", n, rx_ready, rxq.size() < 8);
            end
        end
    endtask

    initial begin
        reset     = 1'b1;
        address   = 16'h0000;
        wr_enable = 1'b0;
        wr_data   = 8'h00;
        tx_ready  = 1'b0;
        rx_valid  = 1'b0;
        rx_data   = 8'h00;
        #12;
        test_reset();
        test_tx_path();
        test_tx_overflow();
        test_rx_path();
        test_full_simul();
        test_ctrl();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
